// File: rtl/mem_array_pkg.sv
// mem_array_pkg: shared widths and load-FSM states for the script memory.
package mem_array_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2**ADDR_W;
    typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO} state_t;
endpackage

// File: rtl/byte_strobe_gen.sv
// byte_strobe_gen: one-cycle accept strobe on a rising valid or a changed byte under held valid.
module byte_strobe_gen (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] bits,
    input  logic       valid,
    output logic       strobe
);
    logic       prev_valid;
    logic [7:0] prev_bits;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_valid <= 1'b0;
            prev_bits  <= '0;
        end else begin
            prev_valid <= valid;
            prev_bits  <= bits;
        end
    end

    assign strobe = valid && (!prev_valid || bits != prev_bits);
endmodule

// File: rtl/mem_array.sv
// mem_array: captures a header-framed word stream into a script array and serves mem[pc].
// SCRIPT_REG_OUT_EN registers the script output (one cycle latency after pc).
module mem_array
    import mem_array_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        dataOut_bits,
    input  logic              dataOut_valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              script_mode,
    output logic [DATA_W-1:0] script,
    output logic [7:0]        script_num
);
    state_t            state, state_d;
    logic [7:0]        hi, hi_d, total, total_d, num_d, num_inc;
    logic              mode_d, strobe, we;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd;

    byte_strobe_gen u_strobe (
        .clock  (clock),
        .reset  (reset),
        .bits   (dataOut_bits),
        .valid  (dataOut_valid),
        .strobe (strobe)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hi          <= '0;
            total       <= '0;
            script_num  <= '0;
            script_mode <= 1'b0;
        end else begin
            state       <= state_d;
            hi          <= hi_d;
            total       <= total_d;
            script_num  <= num_d;
            script_mode <= mode_d;
        end
    end

    assign num_inc = script_num + 8'd1;

    always_comb begin
        state_d = state;
        hi_d    = hi;
        total_d = total;
        num_d   = script_num;
        mode_d  = script_mode;
        we      = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: begin
                    total_d = dataOut_bits;
                    num_d   = '0;
                    mode_d  = dataOut_bits == 8'd0;
                    state_d = dataOut_bits == 8'd0 ? IDLE : LOAD_HI;
                end
                LOAD_HI: begin
                    hi_d    = dataOut_bits;
                    state_d = LOAD_LO;
                end
                LOAD_LO: begin
                    we      = 1'b1;
                    num_d   = num_inc;
                    mode_d  = num_inc == total;
                    state_d = num_inc == total ? IDLE : LOAD_HI;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Array is deliberately not reset; the script_num gate hides stale words.
    always_ff @(posedge clock) begin
        if (we) mem[script_num] <= {hi, dataOut_bits};
    end

    assign rd = (pc < script_num) ? mem[pc] : '0;

`ifdef SCRIPT_REG_OUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) script <= '0;
        else        script <= rd;
    end
`else
    assign script = rd;
`endif
endmodule

// File: tb/tb_mem_array.sv
// tb_mem_array: directed byte streams checked every cycle against a byte-index model of the loader.
module tb_mem_array;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  dataOut_bits = '0;
    logic        dataOut_valid = 1'b0;
    logic [7:0]  pc = '0;
    logic        script_mode;
    logic [15:0] script;
    logic [7:0]  script_num;

    int checks = 0;
    int failures = 0;

    mem_array dut (
        .clock         (clock),
        .reset         (reset),
        .dataOut_bits  (dataOut_bits),
        .dataOut_valid (dataOut_valid),
        .pc            (pc),
        .script_mode   (script_mode),
        .script        (script),
        .script_num    (script_num)
    );

    always #5 clock = ~clock;

    // Model: k is the index of the next byte within the current frame (0 = header expected).
    logic [15:0] m_mem [256];
    logic [7:0]  m_bytes [512];
    int          k = 0;
    logic [7:0]  m_n = '0, m_num = '0;
    logic        m_mode = 1'b0, m_pv = 1'b0;
    logic [7:0]  m_pb = '0;
    logic [15:0] m_reg = '0;

    function automatic logic [15:0] m_read(input logic [7:0] a);
        return (a < m_num) ? m_mem[a] : 16'h0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            k = 0; m_num = '0; m_mode = 1'b0; m_pv = 1'b0; m_pb = '0; m_reg = '0;
        end else begin
            logic       acc;
            logic [7:0] b;
            m_reg = m_read(pc);
            b = dataOut_bits;
            acc = dataOut_valid && (!m_pv || b != m_pb);
            m_pv = dataOut_valid;
            m_pb = b;
            if (acc) begin
                if (k == 0) begin
                    m_n = b; m_num = '0; m_mode = (b == 8'd0); k = (b == 8'd0) ? 0 : 1;
                end else begin
                    m_bytes[k] = b;
                    if (k % 2 == 0) begin
                        m_mem[k/2 - 1] = {m_bytes[k-1], b};
                        m_num = 8'(k/2);
                        if (m_num == m_n) begin m_mode = 1'b1; k = 0; end
                        else k++;
                    end else k++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("cyc_script_num", 32'(script_num), 32'(m_num));
        chk("cyc_script_mode", 32'(script_mode), 32'(m_mode));
`ifdef SCRIPT_REG_OUT_EN
        chk("cyc_script", 32'(script), 32'(m_reg));
`else
        chk("cyc_script", 32'(script), 32'(m_read(pc)));
`endif
    end

    task automatic step(input logic [7:0] b, input logic v);
        @(posedge clock); #2;
        dataOut_bits = b;
        dataOut_valid = v;
    endtask

    task automatic send(input logic [7:0] bs [$]);
        foreach (bs[i]) step(bs[i], 1'b1);
        step(bs[bs.size()-1], 1'b0);
    endtask

    task automatic set_pc(input logic [7:0] a);
        @(posedge clock); #2;
        pc = a;
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic settle();
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic sync_reset();
        @(posedge clock); #2; reset = 1'b0;
        @(posedge clock); #2; reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        settle();
        // 1: reset state
        chk("rst_script", 32'(script), 32'h0);
        chk("rst_num", 32'(script_num), 32'h0);
        chk("rst_mode", 32'(script_mode), 32'h0);

        // 2: header held for two edges, then one word
        step(8'h01, 1'b1); step(8'h01, 1'b1); step(8'h0D, 1'b1); step(8'h60, 1'b1); step(8'h60, 1'b0);
        settle();
        chk("t2_num", 32'(script_num), 32'h1);
        chk("t2_mode", 32'(script_mode), 32'h1);
        set_pc(8'd0);
        chk("t2_pc0", 32'(script), 32'h0D60);
        set_pc(8'd1);
        chk("t2_pc1", 32'(script), 32'h0);

        // 3: partial load of a 10-word header
        send('{8'h0A, 8'h0D, 8'h60});
        set_pc(8'd0);
        chk("t3_num", 32'(script_num), 32'h1);
        chk("t3_mode", 32'(script_mode), 32'h0);
        chk("t3_pc0", 32'(script), 32'h0D60);
        sync_reset();

        // 4: two words, then empty header
        send('{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
        set_pc(8'd1);
        chk("t4_num", 32'(script_num), 32'h2);
        chk("t4_mode", 32'(script_mode), 32'h1);
        chk("t4_pc1", 32'(script), 32'hABCD);
        send('{8'h00});
        settle();
        chk("t4_empty_num", 32'(script_num), 32'h0);
        chk("t4_empty_mode", 32'(script_mode), 32'h1);
        chk("t4_empty_pc1", 32'(script), 32'h0);
        set_pc(8'd0);
        chk("t4_empty_pc0", 32'(script), 32'h0);

        // 5: repeated 0x55 with valid drop counts twice; held counts once
        step(8'h03, 1'b1); step(8'h55, 1'b1); step(8'h55, 1'b0); step(8'h55, 1'b1);
        step(8'h55, 1'b0); step(8'h55, 1'b1); step(8'h55, 1'b1); step(8'h55, 1'b1);
        step(8'h77, 1'b1); step(8'h77, 1'b0);
        set_pc(8'd1);
        chk("t5_num", 32'(script_num), 32'h2);
        chk("t5_mode", 32'(script_mode), 32'h0);
        chk("t5_pc1", 32'(script), 32'h5577);
        set_pc(8'd0);
        chk("t5_pc0", 32'(script), 32'h5555);

        // 6: async reset between high and low byte
        step(8'h11, 1'b1); step(8'h11, 1'b0);
        @(posedge clock); #3 reset = 1'b0;
        #1;
        chk("t6_async_num", 32'(script_num), 32'h0);
        chk("t6_async_mode", 32'(script_mode), 32'h0);
        chk("t6_async_script", 32'(script), 32'h0);
        @(posedge clock); #2 reset = 1'b1;
        send('{8'h01, 8'hBE, 8'hEF});
        set_pc(8'd0);
        chk("t6_num", 32'(script_num), 32'h1);
        chk("t6_mode", 32'(script_mode), 32'h1);
        chk("t6_pc0", 32'(script), 32'hBEEF);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
